ram_arbiter: RTL and testbench

//  Two-port arbiter sharing the single-port embedded data RAM (shared inout data bus) between instruction fetch (port 0) and load/store (port 1).

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/ram_arb_pick.sv | 35 +++
 rtl/ram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants for the data-RAM arbiter.
//   State encodings for the IDLE -> ACCESS -> RESP sequencer and the port index
//   constants used for the grant register and the winner select.
//   Optional feature macro: RAM_ARB_RR_EN (round-robin arbitration; fixed
//   priority to the load/store port when undefined).
package ram_arb_pkg;

  // Sequencer states, 2-bit legacy encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Requester indices.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  // The port that did not win the current grant.
  function automatic logic other_port(input logic port);
    return (port == PORT_FETCH) ? PORT_LSU : PORT_FETCH;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select for the two-port RAM arbiter.
//   A single requester always wins. On a conflict the winner is rr_ptr_i when
//   RAM_ARB_RR_EN is defined, otherwise the load/store port (index 1).
// Ports:
//   req_i     {p1_req, p0_req}
//   rr_ptr_i  preferred port on conflict (only with RAM_ARB_RR_EN)
//   valid_o   at least one request present
//   idx_o     winning port index (meaningful when valid_o)
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef RAM_ARB_RR_EN
  input  logic       rr_ptr_i,
`endif
  output logic       valid_o,
  output logic       idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = PORT_FETCH;
    case (req_i)
      2'b01:   idx_o = PORT_FETCH;
      2'b10:   idx_o = PORT_LSU;
`ifdef RAM_ARB_RR_EN
      2'b11:   idx_o = rr_ptr_i;
`else
      2'b11:   idx_o = PORT_LSU;
`endif
      default: idx_o = PORT_FETCH;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port embedded data RAM between instruction
// fetch (port 0) and load/store (port 1). One transaction in flight at a time:
// IDLE (arbitrate, latch request) -> ACCESS (one RAM cycle) -> RESP (one-cycle
// ready pulse to the granted port). Out-of-range addresses skip ACCESS and
// answer with err=1 and no RAM cycle.
// Optional feature macro: RAM_ARB_RR_EN selects round-robin arbitration;
// undefined gives fixed priority to port 1.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   pX_req/we/addr/wdata       request from port X, held until pX_ready
//   pX_ready/rdata/err         completion pulse, read data, range error
//   mem_we, mem_addr           RAM control, owned exclusively by this block
//   mem_data                   shared RAM data bus, driven only while mem_we=1
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ready,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,

  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ready,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,

  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  inout  wire  [DW-1:0] mem_data
);

  localparam logic [AW-1:0] AddrLimit = AW'(ADDR_LIMIT);

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          pick_valid;
  logic          pick_idx;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_oor;

`ifdef RAM_ARB_RR_EN
  logic          rr_ptr_q, rr_ptr_d;
`endif

  ram_arb_pick u_pick (
    .req_i    ({p1_req, p0_req}),
`ifdef RAM_ARB_RR_EN
    .rr_ptr_i (rr_ptr_q),
`endif
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  // The loser's inputs are never looked at: only the winner is muxed through.
  always_comb begin
    sel_we    = (pick_idx == PORT_LSU) ? p1_we    : p0_we;
    sel_addr  = (pick_idx == PORT_LSU) ? p1_addr  : p0_addr;
    sel_wdata = (pick_idx == PORT_LSU) ? p1_wdata : p0_wdata;
    sel_oor   = (sel_addr >= AddrLimit);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef RAM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          // Writes and errors report zero data; reads overwrite this in ACCESS.
          rdata_d = '0;
          err_d   = sel_oor;
          state_d = sel_oor ? ST_RESP : ST_ACCESS;
`ifdef RAM_ARB_RR_EN
          rr_ptr_d = other_port(pick_idx);
`endif
        end
      end
      ST_ACCESS: begin
        // RAM drives the bus combinationally for reads; capture at the closing edge.
        if (!we_q) begin
          rdata_d = mem_data;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= PORT_FETCH;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef RAM_ARB_RR_EN
      rr_ptr_q <= PORT_FETCH;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef RAM_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Bus and response outputs decode from state_q so an asynchronous reset
  // drops mem_we (and any pending write) immediately, not at the next edge.
  always_comb begin
    mem_we   = (state_q == ST_ACCESS) && we_q;
    mem_addr = (state_q == ST_ACCESS) ? addr_q : '0;

    p0_ready = (state_q == ST_RESP) && (grant_q == PORT_FETCH);
    p1_ready = (state_q == ST_RESP) && (grant_q == PORT_LSU);
    p0_rdata = p0_ready ? rdata_q : '0;
    p1_rdata = p1_ready ? rdata_q : '0;
    p0_err   = p0_ready && err_q;
    p1_err   = p1_ready && err_q;
  end

  // Released whenever not writing so the RAM can drive read data.
  assign mem_data = mem_we ? wdata_q : {DW{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_ready, p0_err;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_ready, p1_err;
  logic [DW-1:0] p1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  // RAM model on the shared bus: combinational read drive, write at the edge.
  logic [DW-1:0] ram     [256];
  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] ram_drive;
  assign ram_drive = ram[mem_addr[9:2]];
  assign mem_data  = mem_we ? {DW{1'bz}} : ram_drive;
  always @(posedge clk) if (mem_we) ram[mem_addr[9:2]] <= mem_data;

  typedef struct {
    bit            port;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .ADDR_LIMIT(LIMIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_ready (p0_ready),
    .p0_rdata (p0_rdata),
    .p0_err   (p0_err),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_ready (p1_ready),
    .p1_rdata (p1_rdata),
    .p1_err   (p1_err),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  // Every-cycle bus and ready invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (p0_ready && p1_ready) begin
        n_err++;
        $display("FAIL ready_onehot: p0_ready=%0b p1_ready=%0b, required at most one",
                 p0_ready, p1_ready);
      end
      n_cmp++;
      if (!mem_we) begin
        if (mem_data !== ram_drive) begin
          n_err++;
          $display("FAIL bus_release: mem_data=%h, required RAM drive %h", mem_data, ram_drive);
        end
      end else if (mem_addr >= LIMIT) begin
        n_err++;
        $display("FAIL we_in_range: mem_addr=%h with mem_we=1, required < %h", mem_addr, LIMIT);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic clr_req(input bit port);
    if (port) begin
      p1_req = 1'b0; p1_we = 1'b0;
    end else begin
      p0_req = 1'b0; p0_we = 1'b0;
    end
  endtask

  // Reference model: computes the response this request must produce.
  task automatic expect_resp(input bit port, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
    exp_t e;
    e.port  = port;
    e.err   = (addr >= LIMIT);
    e.rdata = (we || e.err) ? '0 : exp_mem[addr[9:2]];
    if (we && !e.err) exp_mem[addr[9:2]] = wdata;
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.port = 1'b0; e.rdata = 'x; e.err = 1'b1;
    end
  endtask

  // Returns the negedge index (1-based) at which a ready is seen, -1 on timeout.
  task automatic wait_ready(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget && lat < 0; k++) begin
      @(negedge clk);
      if (p0_ready || p1_ready) lat = k;
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    clr_req(1'b0);
    clr_req(1'b1);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    @(negedge clk);
    n_cmp++;
    if ({p0_ready, p1_ready, p0_err, p1_err, mem_we} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: {p0_rdy,p1_rdy,p0_err,p1_err,we}=%b, required 00000",
               {p0_ready, p1_ready, p0_err, p1_err, mem_we});
    end
    n_cmp++;
    if (p0_rdata !== '0 || p1_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_rdata: p0=%h p1=%h, required 0", p0_rdata, p1_rdata);
    end
    n_cmp++;
    if (mem_addr !== '0) begin
      n_err++;
      $display("FAIL reset_addr: mem_addr=%h, required 0", mem_addr);
    end
    n_cmp++;
    if (mem_data !== ram_drive) begin
      n_err++;
      $display("FAIL reset_bus: mem_data=%h, required RAM drive %h", mem_data, ram_drive);
    end
    step();
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  // p1 writes, then p0 reads the same word back.
  task automatic test_write_read();
    exp_t e;
    int   lat;
    set_req(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    expect_resp(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    wait_ready(10, lat);
    pop_exp(e);
    n_cmp++;
    if (lat != 3 || p1_ready !== 1'b1) begin
      n_err++;
      $display("FAIL t1_wr_latency: lat=%0d p1_ready=%b, required lat=3 p1_ready=1",
               lat, p1_ready);
    end
    n_cmp++;
    if (p1_err !== e.err || p1_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL t1_wr_resp: err=%b rdata=%h, required err=%b rdata=%h",
               p1_err, p1_rdata, e.err, e.rdata);
    end
    step();
    clr_req(1'b1);
    set_req(1'b0, 1'b0, 32'h10, '0);
    expect_resp(1'b0, 1'b0, 32'h10, '0);
    wait_ready(10, lat);
    pop_exp(e);
    n_cmp++;
    if (lat != 3 || p0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL t1_rd_latency: lat=%0d p0_ready=%b, required lat=3 p0_ready=1",
               lat, p0_ready);
    end
    n_cmp++;
    if (p0_rdata !== e.rdata || p0_err !== e.err) begin
      n_err++;
      $display("FAIL t1_rd_data: rdata=%h err=%b, required rdata=%h err=%b",
               p0_rdata, p0_err, e.rdata, e.err);
    end
    step();
    clr_req(1'b0);
  endtask

  // Both ports request at the same edge right after reset.
  task automatic test_conflict();
    exp_t e;
    int   lat;
    bit   first;
    bit   got;
`ifdef RAM_ARB_RR_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    do_reset();
    set_req(1'b0, 1'b0, 32'h10, '0);
    set_req(1'b1, 1'b0, 32'h14, '0);
    expect_resp(first, 1'b0, first ? 32'h14 : 32'h10, '0);
    expect_resp(~first, 1'b0, first ? 32'h10 : 32'h14, '0);
    for (int i = 0; i < 2; i++) begin
      wait_ready(10, lat);
      pop_exp(e);
      got = p1_ready;
      n_cmp++;
      if (lat != 3 || got !== e.port) begin
        n_err++;
        $display("FAIL t2_order_%0d: port=%0d lat=%0d, required port=%0d lat=3",
                 i, got, lat, e.port);
      end
      n_cmp++;
      if ((got ? p1_rdata : p0_rdata) !== e.rdata) begin
        n_err++;
        $display("FAIL t2_data_%0d: rdata=%h, required %h",
                 i, got ? p1_rdata : p0_rdata, e.rdata);
      end
      step();
      clr_req(got);
    end
  endtask

  // Both ports hold req for 12 cycles; each held req is a fresh request.
  task automatic test_hold_both();
    exp_t e;
    int   seen;
    bit   got;
    bit   order [4];
`ifdef RAM_ARB_RR_EN
    order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    set_req(1'b0, 1'b0, 32'h30, '0);
    set_req(1'b1, 1'b0, 32'h34, '0);
    for (int i = 0; i < 4; i++) expect_resp(order[i], 1'b0, order[i] ? 32'h34 : 32'h30, '0);
    seen = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (p0_ready || p1_ready) begin
        pop_exp(e);
        seen++;
        got = p1_ready;
        n_cmp++;
        if (got !== e.port || k != 3 * seen) begin
          n_err++;
          $display("FAIL t3_grant_%0d: port=%0d cycle=%0d, required port=%0d cycle=%0d",
                   seen, got, k, e.port, 3 * seen);
        end
        n_cmp++;
        if ((got ? p1_rdata : p0_rdata) !== e.rdata) begin
          n_err++;
          $display("FAIL t3_data_%0d: rdata=%h, required %h",
                   seen, got ? p1_rdata : p0_rdata, e.rdata);
        end
      end
    end
    n_cmp++;
    if (seen != 4) begin
      n_err++;
      $display("FAIL t3_count: responses=%0d, required 4", seen);
    end
    step();
    clr_req(1'b0);
    clr_req(1'b1);
  endtask

  // ADDR_LIMIT errors without a RAM cycle; ADDR_LIMIT-4 is served.
  task automatic test_out_of_range();
    exp_t e;
    int   lat;
    set_req(1'b0, 1'b0, 32'h400, '0);
    expect_resp(1'b0, 1'b0, 32'h400, '0);
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_we !== 1'b0 || mem_addr !== '0) begin
        n_err++;
        $display("FAIL t4_bus_idle: mem_we=%b mem_addr=%h, required 0/0", mem_we, mem_addr);
      end
      if (p0_ready || p1_ready) lat = k;
    end
    pop_exp(e);
    n_cmp++;
    if (lat != 2 || p0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL t4_err_latency: lat=%0d p0_ready=%b, required lat=2 p0_ready=1",
               lat, p0_ready);
    end
    n_cmp++;
    if (p0_err !== e.err || p0_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL t4_err_resp: err=%b rdata=%h, required err=%b rdata=%h",
               p0_err, p0_rdata, e.err, e.rdata);
    end
    step();
    clr_req(1'b0);
    set_req(1'b1, 1'b0, 32'h3FC, '0);
    expect_resp(1'b1, 1'b0, 32'h3FC, '0);
    wait_ready(10, lat);
    pop_exp(e);
    n_cmp++;
    if (lat != 3 || p1_err !== e.err || p1_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL t4_last_word: lat=%0d err=%b rdata=%h, required lat=3 err=%b rdata=%h",
               lat, p1_err, p1_rdata, e.err, e.rdata);
    end
    step();
    clr_req(1'b1);
  endtask

  // Reset during ACCESS of a write: nothing is committed.
  task automatic test_reset_mid_write();
    exp_t e;
    int   lat;
    set_req(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(posedge clk);
    #2;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h20) begin
      n_err++;
      $display("FAIL t5_access: mem_we=%b mem_addr=%h, required 1/00000020", mem_we, mem_addr);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || p1_ready !== 1'b0 || p1_err !== 1'b0) begin
      n_err++;
      $display("FAIL t5_async_clear: we=%b addr=%h rdy=%b err=%b, required all 0",
               mem_we, mem_addr, p1_ready, p1_err);
    end
    clr_req(1'b1);
    step();
    step();
    rst = 1'b0;
    set_req(1'b0, 1'b0, 32'h20, '0);
    expect_resp(1'b0, 1'b0, 32'h20, '0);
    wait_ready(10, lat);
    pop_exp(e);
    n_cmp++;
    if (lat != 3 || p0_rdata !== e.rdata || p0_err !== e.err) begin
      n_err++;
      $display("FAIL t5_old_data: lat=%0d rdata=%h err=%b, required lat=3 rdata=%h err=%b",
               lat, p0_rdata, p0_err, e.rdata, e.err);
    end
    step();
    clr_req(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 32'hA500_0000 + 32'(i);
      exp_mem[i] = 32'hA500_0000 + 32'(i);
    end
    test_reset();
    test_write_read();
    test_conflict();
    test_hold_both();
    test_out_of_range();
    test_reset_mid_write();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected responses never seen, required 0", sb.size());
    end
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
